// File: rtl/orde_rd_return_ctrl.sv
// -----------------------------------------------------------------------------
// orde_rd_return_ctrl
//
// This block sits downstream of the ordering response buffer. It queues the
// popped ordered-response metadata, because the pop-packet stream cannot be
// stalled. For each queued entry it captures the buffer's head data word and
// then does one of three things:
//   - RETURN   (rd_type 2'b00) : presents the word on the host read-return
//                                channel and waits for the valid/ready
//                                handshake.
//   - REG_LOAD (rd_type 2'b01) : loads the indirect-addressing base registers
//                                A/B/C. The mask is taken from data[226:224].
//   - DROP     (rd_type 2'b1x) : discards the word.
// Each entry consumes the head data word with a single o_data_pop pulse.
// After that pulse, the block waits DATA_SETTLE cycles before it samples
// i_data again.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   i_pop_pkt(_valid) : popped metadata, one-cycle valid, no backpressure
//   i_data            : head data word of the response buffer
//   o_data_pop        : one-cycle pulse consuming the head data word
//   o_rd_valid/i_rd_ready, o_rd_meta, o_rd_data : host read-return channel
//   o_reg_A/B/C_data  : indirect-addressing base registers
//   o_meta_afull      : metadata queue count >= META_DEPTH-2
//   o_meta_ovf        : sticky, a push was dropped on a full queue
//   o_ret_cnt         : completed host returns (wraps)
// -----------------------------------------------------------------------------
module orde_rd_return_ctrl #(
  parameter int unsigned META_W      = 32,
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned META_DEPTH  = 8,
  parameter int unsigned DATA_SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [META_W-1:0]     i_pop_pkt,
  input  logic                  i_pop_pkt_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_data_pop,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [META_W-1:0]     o_rd_meta,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [31:0]           o_reg_A_data,
  output logic [31:0]           o_reg_B_data,
  output logic [31:0]           o_reg_C_data,
  output logic                  o_meta_afull,
  output logic                  o_meta_ovf,
  output logic [15:0]           o_ret_cnt
);

  localparam int unsigned PTR_W = $clog2(META_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SET_W = (DATA_SETTLE > 1) ? $clog2(DATA_SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(DATA_SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [SET_W-1:0]        settle_q, settle_d;
  logic [META_W-1:0]       mem_q [META_DEPTH];
  logic [META_W-1:0]       mem_d [META_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic [META_W-1:0]       rd_meta_q, rd_meta_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [31:0]             reg_a_q, reg_a_d;
  logic [31:0]             reg_b_q, reg_b_d;
  logic [31:0]             reg_c_q, reg_c_d;
  logic [15:0]             ret_cnt_q, ret_cnt_d;

  logic                    q_full;
  logic                    q_empty;
  logic                    q_push;
  logic                    q_pop;
  logic                    data_pop_c;
  logic                    rd_valid_c;
  logic [1:0]              cur_type;
  logic [2:0]              load_mask;

  assign q_full    = (cnt_q == CNT_W'(META_DEPTH));
  assign q_empty   = (cnt_q == '0);
  assign cur_type  = rd_meta_q[META_W-1 -: 2];
  assign load_mask = rd_data_q[226:224];

  // A push that arrives while the queue is full still succeeds when the same
  // cycle dequeues an entry, because a slot is freed in that cycle.
  assign q_push = i_pop_pkt_valid && (!q_full || q_pop);

  // ---------------------------------------------------------------------------
  // Metadata queue
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (q_push) begin
      mem_d[wr_ptr_q] = i_pop_pkt;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (q_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(q_push) - CNT_W'(q_pop);

    if (i_pop_pkt_valid && q_full && !q_pop) begin
      ovf_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Return / register-load FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    rd_meta_d  = rd_meta_q;
    rd_data_d  = rd_data_q;
    reg_a_d    = reg_a_q;
    reg_b_d    = reg_b_q;
    reg_c_d    = reg_c_q;
    ret_cnt_d  = ret_cnt_q;
    q_pop      = 1'b0;
    data_pop_c = 1'b0;
    rd_valid_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!q_empty && (settle_q == '0)) begin
          rd_meta_d = mem_q[rd_ptr_q];
          rd_data_d = i_data;
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // The entry stays in the queue until it is retired here. The queue
        // count therefore includes the entry that is being issued.
        unique case (cur_type)
          2'b00: begin
            rd_valid_c = 1'b1;
            if (i_rd_ready) begin
              data_pop_c = 1'b1;
              q_pop      = 1'b1;
              ret_cnt_d  = ret_cnt_q + 16'd1;
              settle_d   = SETTLE_LOAD;
              state_d    = S_SETTLE;
            end
          end
          2'b01: begin
            if (load_mask[0]) reg_a_d = rd_data_q[31:0];
            if (load_mask[1]) reg_b_d = rd_data_q[63:32];
            if (load_mask[2]) reg_c_d = rd_data_q[95:64];
            data_pop_c = 1'b1;
            q_pop      = 1'b1;
            settle_d   = SETTLE_LOAD;
            state_d    = S_SETTLE;
          end
          default: begin
            data_pop_c = 1'b1;
            q_pop      = 1'b1;
            settle_d   = SETTLE_LOAD;
            state_d    = S_SETTLE;
          end
        endcase
      end

      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_IDLE;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      rd_meta_q <= '0;
      rd_data_q <= '0;
      reg_a_q   <= '0;
      reg_b_q   <= '0;
      reg_c_q   <= '0;
      ret_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rd_meta_q <= rd_meta_d;
      rd_data_q <= rd_data_d;
      reg_a_q   <= reg_a_d;
      reg_b_q   <= reg_b_d;
      reg_c_q   <= reg_c_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The strobes are masked while reset is asserted. A response that is
  // abandoned by reset is neither popped from the buffer nor handed to the
  // host.
  assign o_data_pop   = data_pop_c & ~rst;
  assign o_rd_valid   = rd_valid_c & ~rst;
  assign o_rd_meta    = rd_meta_q;
  assign o_rd_data    = rd_data_q;
  assign o_reg_A_data = reg_a_q;
  assign o_reg_B_data = reg_b_q;
  assign o_reg_C_data = reg_c_q;
  assign o_meta_afull = (cnt_q >= CNT_W'(META_DEPTH - 2));
  assign o_meta_ovf   = ovf_q;
  assign o_ret_cnt    = ret_cnt_q;

endmodule

// File: doc/orde_rd_return_ctrl.md
Name: orde_rd_return_ctrl

Overview:
- Sits directly downstream of the ordering response buffer.
- Consumes popped ordered-response metadata and the head data word. It issues the data pop strobe back to the buffer, then routes each response to one of three places:
  - host read-return channel (valid/ready),
  - indirect-addressing base registers A/B/C,
  - discard.
- The register outputs drive the buffer's i_reg_A/B/C_data inputs.
- The pop-packet stream has no backpressure, so metadata is queued internally.

Parameters:
- META_W, 32, width of popped metadata; bits [META_W-1:META_W-2] are rd_type.
- DATA_WIDTH, 256, response data width.
- META_DEPTH, 8, metadata queue depth (power of 2, ≥2).
- DATA_SETTLE, 2, cycles after a data pop before i_data reflects the new head (2 covers the indirect-address register stage).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_pop_pkt  in  META_W  popped metadata
- i_pop_pkt_valid  in  1  one-cycle metadata valid; no backpressure
- i_data  in  DATA_WIDTH  head data word of the buffer
- o_data_pop  out  1  one-cycle pulse consuming the head data word
- o_rd_valid  out  1  host return valid
- i_rd_ready  in  1  host return ready
- o_rd_meta  out  META_W  metadata of the returned word
- o_rd_data  out  DATA_WIDTH  returned data
- o_reg_A_data / o_reg_B_data / o_reg_C_data  out  32 each  indirect base registers
- o_meta_afull  out  1  queue count ≥ META_DEPTH-2
- o_meta_ovf  out  1  sticky: a push was dropped because the queue was full
- o_ret_cnt  out  16  number of host returns completed (wraps)

Behaviour:
- Reset (clk edge with rst=1) clears everything listed below; all outputs read 0 the cycle after reset:
  - queue pointers and count
  - state = IDLE
  - settle counter = 0
  - o_data_pop = 0, o_rd_valid = 0
  - o_rd_meta and o_rd_data = 0
  - o_reg_A/B/C = 0
  - o_meta_ovf = 0, o_ret_cnt = 0
- Reset mid-transfer abandons the in-flight response; no data pop is issued for it.
- Metadata queue (FIFO, META_DEPTH entries, count width clog2(META_DEPTH)+1):
  - Push on i_pop_pkt_valid.
  - Push while full: entry dropped, o_meta_ovf set. The flag is cleared only by rst.
  - Simultaneous push and pop while full: both occur, count unchanged, no overflow.
  - Pointers wrap modulo META_DEPTH.
- rd_type decode: 2'b00 RETURN, 2'b01 REG_LOAD, 2'b10/2'b11 DROP.
- FSM states: IDLE, ISSUE, SETTLE.
  - IDLE: if queue non-empty and settle counter = 0, then:
    - capture the head meta into o_rd_meta and i_data into o_rd_data,
    - go to ISSUE.
  - ISSUE, RETURN:
    - o_rd_valid = 1; o_rd_meta and o_rd_data are held stable until i_rd_ready.
    - On handshake: o_data_pop = 1 for that cycle, queue pop, o_ret_cnt += 1, go to SETTLE.
  - ISSUE, REG_LOAD (single cycle, no o_rd_valid):
    - Mask = o_rd_data[226:224].
    - Update o_reg_A ← word0 if mask[0]; o_reg_B ← word1 if mask[1]; o_reg_C ← word2 if mask[2] (wordN = o_rd_data[32N+31:32N]).
    - o_data_pop = 1, queue pop, go to SETTLE.
  - ISSUE, DROP: o_data_pop = 1, queue pop, go to SETTLE (single cycle).
  - SETTLE: load settle counter = DATA_SETTLE-1; decrement each cycle; go to IDLE when it reaches 0.
  - DATA_SETTLE = 1: SETTLE lasts one cycle.
- Latency: metadata pushed in cycle t into an empty queue with the FSM in IDLE → o_rd_valid high in cycle t+2. With ready held high, the minimum spacing between consecutive pops is 2+DATA_SETTLE cycles.
- o_data_pop is never asserted outside ISSUE; exactly one pulse per dequeued metadata entry.
- o_ret_cnt wraps 16'hFFFF→0.
- o_meta_afull is combinational from the count.

Test Plan:
- Reset, then push one RETURN meta 0x0000_1234 with i_data = 0xAA..AA, i_rd_ready=1:
  - o_rd_valid rises at t+2 with o_rd_meta = 0x1234;
  - one o_data_pop pulse; o_ret_cnt = 1.
- RETURN with i_rd_ready held 0 for 5 cycles, while i_data changes after capture:
  - o_rd_valid stays high; o_rd_data is unchanged;
  - o_data_pop fires only in the ready cycle.
- REG_LOAD, mask 3'b101, words 0/1/2 = 0x100/0x200/0x300:
  - o_reg_A = 0x100, o_reg_B = 0, o_reg_C = 0x300;
  - no o_rd_valid; one o_data_pop.
- DROP (rd_type 2'b11): one o_data_pop; no o_rd_valid; registers and o_ret_cnt unchanged.
- Overflow: hold ready=0, push 10 metas with META_DEPTH=8:
  - o_meta_afull at count 6; o_meta_ovf set on push 9 (one entry held in ISSUE);
  - on release, exactly 8 returns in push order.
- Assert rst while in ISSUE with ready=0: next cycle o_rd_valid=0, queue empty, registers 0, no o_data_pop.
